// File: rtl/hpu_sprite_fetch.sv
// Sprite fetch: scans OAM for one target line and fills NUM_SLOTS sprite engine slots.
// Latency: 2 cycles per missing OAM entry, 14 per hit, plus one COMMIT cycle.
// Backpressure: none; memory answers every read in the next cycle, and start is ignored while busy.
//
// Ports:
//   clk, reset         sole clock, synchronous active-high reset
//   start, target_line one-cycle scan request and the half-resolution line to prepare
//   addr_out, data_in  byte-wide memory read port (data returns one cycle after the address)
//   sprite_*_out       per-slot x, y, pallet and 8-pixel row (3 bits per pixel), packed slot-major
//   slot_valid         per-slot occupancy for the committed line
//   busy, overflow     scan in progress; committed line had more hits than slots
module hpu_sprite_fetch #(
  parameter int          NUM_SLOTS   = 16,
  parameter int          OAM_ENTRIES = 64,
  parameter logic [15:0] OAM_BASE    = 16'hF000,
  parameter logic [15:0] TILE_BASE   = 16'h8000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              target_line,
  output logic [15:0]             addr_out,
  input  logic [7:0]              data_in,
  output logic [8*NUM_SLOTS-1:0]  sprite_x_out,
  output logic [8*NUM_SLOTS-1:0]  sprite_y_out,
  output logic [2*NUM_SLOTS-1:0]  sprite_pallet_out,
  output logic [24*NUM_SLOTS-1:0] line_buf_out,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  output logic                    busy,
  output logic                    overflow
);

  // Counters are one bit wider than strictly needed so slot_cnt can reach NUM_SLOTS
  // (the "all slots full" condition) without wrapping.
  localparam int EW = $clog2(OAM_ENTRIES + 1);
  localparam int SW = $clog2(NUM_SLOTS + 1);

  typedef enum logic [3:0] {
    IDLE,
    Y_ADDR,
    Y_CAP,
    X_ADDR,
    X_CAP,
    T_ADDR,
    T_CAP,
    A_ADDR,
    A_CAP,
    R0_ADDR,
    R0_CAP,
    R1_ADDR,
    R1_CAP,
    R2_ADDR,
    R2_CAP,
    COMMIT
  } state_t;

  state_t state;

  logic [EW-1:0] entry_cnt;
  logic [SW-1:0] slot_cnt;
  logic [7:0]    line_q;

  // Attributes of the entry currently being fetched
  logic [7:0]    cur_y;
  logic [7:0]    cur_x;
  logic [7:0]    cur_tile;
  logic [1:0]    cur_pal;
  logic [2:0]    row_q;
  logic [7:0]    byte0;
  logic [7:0]    byte1;

  // Shadow copy built during the scan; outputs keep the previous line until COMMIT
  logic [8*NUM_SLOTS-1:0]  sh_x;
  logic [8*NUM_SLOTS-1:0]  sh_y;
  logic [2*NUM_SLOTS-1:0]  sh_pal;
  logic [24*NUM_SLOTS-1:0] sh_lb;
  logic [NUM_SLOTS-1:0]    sh_valid;
  logic                    sh_ovf;

  logic [7:0]  row_diff;
  logic        row_hit;
  logic        last_entry;
  logic        slots_full;
  logic [15:0] oam_addr;
  logic [15:0] next_oam_addr;
  logic [15:0] tile_row_addr;

  // Row inside the sprite wraps modulo 256, so sprites near y=255 still hit low lines.
  assign row_diff      = line_q - data_in;
  assign row_hit       = (row_diff < 8'd8);
  assign last_entry    = (entry_cnt == EW'(OAM_ENTRIES - 1));
  assign slots_full    = (slot_cnt == SW'(NUM_SLOTS));
  assign oam_addr      = OAM_BASE + (16'(entry_cnt) << 2);
  assign next_oam_addr = OAM_BASE + (16'(entry_cnt + EW'(1)) << 2);
  // Each tile is 8 rows x 3 bytes; the sum wraps at 16 bits on purpose.
  assign tile_row_addr = TILE_BASE + 16'(cur_tile) * 16'd24 + 16'(row_q) * 16'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      addr_out          <= '0;
      busy              <= 1'b0;
      overflow          <= 1'b0;
      slot_valid        <= '0;
      sprite_x_out      <= '0;
      sprite_y_out      <= '0;
      sprite_pallet_out <= '0;
      line_buf_out      <= '0;
      sh_x              <= '0;
      sh_y              <= '0;
      sh_pal            <= '0;
      sh_lb             <= '0;
      sh_valid          <= '0;
      sh_ovf            <= 1'b0;
      entry_cnt         <= '0;
      slot_cnt          <= '0;
      line_q            <= '0;
      cur_y             <= '0;
      cur_x             <= '0;
      cur_tile          <= '0;
      cur_pal           <= '0;
      row_q             <= '0;
      byte0             <= '0;
      byte1             <= '0;
    end else begin
      case (state)
        IDLE: begin
          addr_out <= '0;
          if (start) begin
            state     <= Y_ADDR;
            busy      <= 1'b1;
            entry_cnt <= '0;
            slot_cnt  <= '0;
            line_q    <= target_line;
            // Clearing the shadow data makes unfilled slots commit as zero.
            sh_x      <= '0;
            sh_y      <= '0;
            sh_pal    <= '0;
            sh_lb     <= '0;
            sh_valid  <= '0;
            sh_ovf    <= 1'b0;
            addr_out  <= OAM_BASE;
          end
        end

        Y_ADDR: state <= Y_CAP;

        Y_CAP: begin
          cur_y <= data_in;
          row_q <= row_diff[2:0];
          if (row_hit && slots_full) begin
            // One hit too many: the line is over-subscribed, stop scanning.
            sh_ovf   <= 1'b1;
            busy     <= 1'b0;
            addr_out <= '0;
            state    <= COMMIT;
          end else if (row_hit) begin
            addr_out <= oam_addr + 16'd1;
            state    <= X_ADDR;
          end else if (last_entry) begin
            busy     <= 1'b0;
            addr_out <= '0;
            state    <= COMMIT;
          end else begin
            entry_cnt <= entry_cnt + EW'(1);
            addr_out  <= next_oam_addr;
            state     <= Y_ADDR;
          end
        end

        X_ADDR: state <= X_CAP;

        X_CAP: begin
          cur_x    <= data_in;
          addr_out <= oam_addr + 16'd2;
          state    <= T_ADDR;
        end

        T_ADDR: state <= T_CAP;

        T_CAP: begin
          cur_tile <= data_in;
          addr_out <= oam_addr + 16'd3;
          state    <= A_ADDR;
        end

        A_ADDR: state <= A_CAP;

        A_CAP: begin
          cur_pal  <= data_in[1:0];
          // cur_tile and row_q are both settled here, so the tile row address is valid.
          addr_out <= tile_row_addr;
          state    <= R0_ADDR;
        end

        R0_ADDR: state <= R0_CAP;

        R0_CAP: begin
          byte0    <= data_in;
          addr_out <= tile_row_addr + 16'd1;
          state    <= R1_ADDR;
        end

        R1_ADDR: state <= R1_CAP;

        R1_CAP: begin
          byte1    <= data_in;
          addr_out <= tile_row_addr + 16'd2;
          state    <= R2_ADDR;
        end

        R2_ADDR: state <= R2_CAP;

        R2_CAP: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_cnt == SW'(i)) begin
              sh_x[8*i +: 8]    <= cur_x;
              sh_y[8*i +: 8]    <= cur_y;
              sh_pal[2*i +: 2]  <= cur_pal;
              // Leftmost pixels come from the first byte of the row.
              sh_lb[24*i +: 24] <= {byte0, byte1, data_in};
              sh_valid[i]       <= 1'b1;
            end
          end
          slot_cnt <= slot_cnt + SW'(1);
          if (last_entry) begin
            busy     <= 1'b0;
            addr_out <= '0;
            state    <= COMMIT;
          end else begin
            entry_cnt <= entry_cnt + EW'(1);
            addr_out  <= next_oam_addr;
            state     <= Y_ADDR;
          end
        end

        COMMIT: begin
          // Whole line becomes visible at once so the renderer never sees a partial update.
          sprite_x_out      <= sh_x;
          sprite_y_out      <= sh_y;
          sprite_pallet_out <= sh_pal;
          line_buf_out      <= sh_lb;
          slot_valid        <= sh_valid;
          overflow          <= sh_ovf;
          addr_out          <= '0;
          state             <= IDLE;
        end

        default: begin
          addr_out <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpu_sprite_fetch.sv
// Bench for hpu_sprite_fetch: byte memory model, directed scans, slot scoreboard.
module tb_hpu_sprite_fetch;
  localparam int NS = 16;
  localparam int NE = 64;
  localparam logic [15:0] OAMB = 16'hF000;
  localparam logic [15:0] TILEB = 16'h8000;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [7:0]         target_line;
  logic [15:0]        addr_out;
  logic [7:0]         data_in;
  logic [8*NS-1:0]    sprite_x_out;
  logic [8*NS-1:0]    sprite_y_out;
  logic [2*NS-1:0]    sprite_pallet_out;
  logic [24*NS-1:0]   line_buf_out;
  logic [NS-1:0]      slot_valid;
  logic               busy;
  logic               overflow;

  always #5 clk = ~clk;

  hpu_sprite_fetch #(
    .NUM_SLOTS(NS), .OAM_ENTRIES(NE), .OAM_BASE(OAMB), .TILE_BASE(TILEB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .target_line(target_line),
    .addr_out(addr_out), .data_in(data_in),
    .sprite_x_out(sprite_x_out), .sprite_y_out(sprite_y_out),
    .sprite_pallet_out(sprite_pallet_out), .line_buf_out(line_buf_out),
    .slot_valid(slot_valid), .busy(busy), .overflow(overflow)
  );

  // Memory: byte addressed on addr_out in cycle n appears on data_in in cycle n+1.
  logic [7:0] mem [0:65535];
  always @(posedge clk) data_in <= mem[addr_out];

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [1:0]  pal;
    logic [23:0] lb;
  } slot_t;

  slot_t       sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [NS-1:0] prev_valid = '0;
  logic          prev_ovf = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_oam(input int k, input logic [7:0] y, input logic [7:0] x,
                         input logic [7:0] t, input logic [7:0] a);
    mem[OAMB + 16'(4*k)]     = y;
    mem[OAMB + 16'(4*k + 1)] = x;
    mem[OAMB + 16'(4*k + 2)] = t;
    mem[OAMB + 16'(4*k + 3)] = a;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 64'(addr_out), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_valid"}, 64'(slot_valid), 64'(0));
    chk({tag, "_data"}, 64'(|{sprite_x_out, sprite_y_out, sprite_pallet_out, line_buf_out}), 64'(0));
  endtask

  // Reference scan of the memory image, then drive one scan and compare the committed line.
  task automatic run_line(input logic [7:0] tl, input bit mid_start,
                          input logic [15:0] watch, output logic [2:0] seen);
    slot_t         arr [NS];
    slot_t         e;
    logic [NS-1:0] valid;
    logic          ovf;
    logic [7:0]    y, row, t;
    logic [15:0]   base;
    int            s, cyc, n;
    valid = '0; ovf = 1'b0; s = 0; cyc = 0; seen = 3'b000;
    for (int i = 0; i < NS; i++) arr[i] = '0;
    for (int k = 0; k < NE; k++) begin
      y   = mem[OAMB + 16'(4*k)];
      row = tl - y;
      cyc += 2;
      if (row < 8'd8) begin
        if (s == NS) begin
          ovf = 1'b1;
          break;
        end
        cyc += 12;
        t    = mem[OAMB + 16'(4*k + 2)];
        base = TILEB + 16'(t) * 16'd24 + 16'(row) * 16'd3;
        arr[s].x   = mem[OAMB + 16'(4*k + 1)];
        arr[s].y   = y;
        arr[s].pal = mem[OAMB + 16'(4*k + 3)][1:0];
        arr[s].lb  = {mem[base], mem[base + 16'd1], mem[base + 16'd2]};
        valid[s] = 1'b1;
        s++;
      end
    end
    for (int i = 0; i < NS; i++) sbq.push_back(arr[i]);

    target_line = tl;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      for (int j = 0; j < 3; j++)
        if (addr_out == watch + 16'(j)) seen[j] = 1'b1;
      if (mid_start && n == 30) begin
        chk("hold_valid", 64'(slot_valid), 64'(prev_valid));
        chk("hold_ovf", 64'(overflow), 64'(prev_ovf));
      end
      start = (mid_start && n == 20);
      tick();
      start = 1'b0;
    end
    chk("busy_cycles", 64'(n), 64'(cyc));
    tick();
    chk("slot_valid", 64'(slot_valid), 64'(valid));
    chk("overflow", 64'(overflow), 64'(ovf));
    chk("addr_idle", 64'(addr_out), 64'(0));
    for (int i = 0; i < NS; i++) begin
      e = sbq.pop_front();
      chk($sformatf("slot%0d", i),
          64'({sprite_x_out[8*i +: 8], sprite_y_out[8*i +: 8],
               sprite_pallet_out[2*i +: 2], line_buf_out[24*i +: 24]}),
          64'(e));
    end
    prev_valid = valid;
    prev_ovf   = ovf;
  endtask

  initial begin
    logic [2:0]  seen;
    logic [15:0] r1;
    bit          found;

    reset = 1'b1; start = 1'b0; target_line = 8'd0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < NE; k++) set_oam(k, 8'd100, 8'($urandom), 8'($urandom), 8'($urandom));

    // Reset state, also with start asserted alongside reset
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_zero("rst");
    reset = 1'b0;
    tick();
    check_zero("post_rst");

    // All entries miss line 10
    run_line(8'd10, 1'b0, 16'h0000, seen);

    // Single hit at entry 3, row 2 of tile 2
    set_oam(3, 8'd8, 8'd40, 8'd2, 8'd1);
    run_line(8'd10, 1'b0, 16'h8036, seen);
    chk("row_addrs_seen", 64'(seen), 64'(3'b111));
    chk("s0_x", 64'(sprite_x_out[7:0]), 64'(8'd40));
    chk("s0_pal", 64'(sprite_pallet_out[1:0]), 64'(2'd1));
    set_oam(3, 8'd100, 8'd0, 8'd0, 8'd0);

    // Vertical wrap: y=250 covers lines 250..255 and 0..1
    set_oam(5, 8'd250, 8'd77, 8'd9, 8'd2);
    run_line(8'd1, 1'b0, 16'h0000, seen);
    chk("wrap_hit", 64'(slot_valid), 64'(16'h0001));
    run_line(8'd2, 1'b0, 16'h0000, seen);
    chk("wrap_miss", 64'(slot_valid), 64'(16'h0000));
    set_oam(5, 8'd100, 8'd0, 8'd0, 8'd0);

    // 20 hits on line 20: first 16 fill the slots, then overflow
    for (int i = 0; i < 20; i++)
      set_oam(i, 8'(20 - (i % 8)), 8'(3*i + 1), 8'(i), 8'(i % 4));
    run_line(8'd20, 1'b0, 16'h0000, seen);
    chk("ovf_valid", 64'(slot_valid), 64'(16'hFFFF));
    chk("ovf_flag", 64'(overflow), 64'(1));

    // Second start during a scan is ignored; old line held until commit
    for (int i = 0; i < 20; i++) set_oam(i, 8'd100, 8'd0, 8'd0, 8'd0);
    run_line(8'd20, 1'b1, 16'h0000, seen);

    // Commit a known line, then abort a rescan in R1_CAP with reset
    set_oam(0, 8'd8, 8'd55, 8'd4, 8'd3);
    run_line(8'd10, 1'b0, 16'h0000, seen);
    r1 = TILEB + 16'd96 + 16'd6 + 16'd1;
    target_line = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (addr_out == r1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("r1_addr_seen", 64'(found), 64'(1));
    tick();             // now in R1_CAP
    reset = 1'b1;
    tick();
    check_zero("abort");
    reset = 1'b0;
    for (int c = 0; c < 150; c++) tick();
    check_zero("no_commit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
